// File: rtl/branch_resolve_stage_if.sv
// Purpose : handshake bundle for branch_resolve_stage (entry in, resolved result out).
// Latency : n/a (wires only).
// Backpressure: in_ready / out_ready carry the valid/ready handshakes in each direction.
// Ports   : slave  = the stage (consumes in_*, out_ready; drives in_ready, out_*)
//           master = the environment around the stage (the mirror view).
interface branch_resolve_stage_if #(
  parameter int XLEN = 64,
  parameter int PC_W = 64
);
  // upstream channel
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic            in_a_msb;
  logic            in_b_msb;
  logic [XLEN-1:0] in_diff;
  logic            in_borrow;
  logic [PC_W-1:0] in_pc;
  logic [PC_W-1:0] in_imm;
  logic            in_pred_taken;
  // downstream channel
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [PC_W-1:0] out_next_pc;
  logic            out_redirect;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_funct3, in_a_msb, in_b_msb, in_diff, in_borrow,
           in_pc, in_imm, in_pred_taken, out_ready,
    output in_ready, out_valid, out_taken, out_next_pc, out_redirect, out_illegal
  );

  modport master (
    output in_valid, in_funct3, in_a_msb, in_b_msb, in_diff, in_borrow,
           in_pc, in_imm, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_taken, out_next_pc, out_redirect, out_illegal
  );
endinterface

// File: rtl/branch_resolve_stage.sv
// Purpose : resolve RV64 conditional branches from subtractor result; compute next PC and redirect.
// Latency : 1 cycle (entry accepted at edge N is on out_* after edge N).
// Backpressure: 2-entry skid (main + skid); in_ready = !skid_valid, registered; outputs held while stalled.
// Ports   : i_clk, i_rst_n (sync active-low), i_flush (kill all entries), bus (slave view of
//           branch_resolve_stage_if). Optional BRANCH_STATS_EN adds o_stat_taken / o_stat_redirect,
//           saturating 32-bit counters of delivered taken / redirected results.
module branch_resolve_stage #(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_flush,
  branch_resolve_stage_if.slave       bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]                 o_stat_taken,
  output logic [31:0]                 o_stat_redirect
`endif
);

  typedef struct packed {
    logic            taken;
    logic            redirect;
    logic            illegal;
    logic [PC_W-1:0] next_pc;
  } res_t;

  logic w_eq, w_lt, w_ltu, w_cond;
  res_t w_res;
  logic w_in_fire, w_out_fire;

  res_t r_main, r_skid;
  logic r_main_vld, r_skid_vld;

  assign w_eq  = (bus.in_diff == '0);
  assign w_ltu = bus.in_borrow;
  // signs differ: rs1 is the negative one iff its msb is set; otherwise no overflow, use diff sign
  assign w_lt  = (bus.in_a_msb != bus.in_b_msb) ? bus.in_a_msb : bus.in_diff[XLEN-1];

  always_comb begin
    w_cond         = 1'b0;
    w_res.illegal  = 1'b0;
    case (bus.in_funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = !w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = !w_ltu;
      default: w_res.illegal = 1'b1;  // 010 / 011: never taken
    endcase
    w_res.taken    = w_cond;
    w_res.redirect = w_cond ^ bus.in_pred_taken;
    w_res.next_pc  = w_cond ? (bus.in_pc + bus.in_imm) : (bus.in_pc + PC_W'(4));
  end

  assign w_in_fire  = bus.in_valid & !r_skid_vld;
  assign w_out_fire = r_main_vld & bus.out_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (i_flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (!r_main_vld || w_out_fire) begin
      // main is free next cycle: skid has priority to keep FIFO order
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_in_fire) begin
        r_main     <= w_res;
        r_main_vld <= 1'b1;
      end else begin
        r_main_vld <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid     <= w_res;
      r_skid_vld <= 1'b1;
    end
  end

  assign bus.in_ready     = !r_skid_vld;
  assign bus.out_valid    = r_main_vld;
  assign bus.out_taken    = r_main.taken;
  assign bus.out_next_pc  = r_main.next_pc;
  assign bus.out_redirect = r_main.redirect;
  assign bus.out_illegal  = r_main.illegal;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_taken, r_stat_redirect;

  // a handshake in a flush cycle is still a delivery, so flush does not gate counting
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stat_taken    <= '0;
      r_stat_redirect <= '0;
    end else if (w_out_fire) begin
      if (r_main.taken && (r_stat_taken != '1))
        r_stat_taken <= r_stat_taken + 32'd1;
      if (r_main.redirect && (r_stat_redirect != '1))
        r_stat_redirect <= r_stat_redirect + 32'd1;
    end
  end

  assign o_stat_taken    = r_stat_taken;
  assign o_stat_redirect = r_stat_redirect;
`endif

endmodule
